// File: rtl/evo_csr_arb_if.sv
// Bus bundle between the CSR masters, the arbiter and the crossbar CSR slave port.
// Avalon-MM: a command is accepted in the cycle where read/write is high and waitrequest is low;
// readdatavalid is a one-cycle strobe carrying the data of one earlier accepted read.
interface evo_csr_arb_if #(
  parameter int NUM_MASTERS = 2,
  parameter int AWIDTH      = 8,
  parameter int DWIDTH      = 32
);
  logic [NUM_MASTERS*AWIDTH-1:0] m_address;
  logic [NUM_MASTERS-1:0]        m_read;
  logic [NUM_MASTERS-1:0]        m_write;
  logic [NUM_MASTERS*DWIDTH-1:0] m_writedata;
  logic [NUM_MASTERS-1:0]        m_waitrequest;
  logic [DWIDTH-1:0]             m_readdata;
  logic [NUM_MASTERS-1:0]        m_readdatavalid;

  logic [AWIDTH-1:0]             s_address;
  logic                          s_read;
  logic                          s_write;
  logic [DWIDTH-1:0]             s_writedata;
  logic                          s_waitrequest;
  logic [DWIDTH-1:0]             s_readdata;
  logic                          s_readdatavalid;

  // Arbiter view: slave towards the BSP masters, master towards the crossbar.
  modport slave (
    input  m_address, m_read, m_write, m_writedata,
    input  s_waitrequest, s_readdata, s_readdatavalid,
    output m_waitrequest, m_readdata, m_readdatavalid,
    output s_address, s_read, s_write, s_writedata
  );

  // Environment view: the requesting masters plus the crossbar slave port.
  modport master (
    output m_address, m_read, m_write, m_writedata,
    output s_waitrequest, s_readdata, s_readdatavalid,
    input  m_waitrequest, m_readdata, m_readdatavalid,
    input  s_address, s_read, s_write, s_writedata
  );
endinterface

// File: rtl/evo_csr_arb.sv
// Round-robin arbiter sharing the crossbar CSR slave port between NUM_MASTERS masters,
// one transaction in flight, with a per-transaction timeout for forced completion.
module evo_csr_arb #(
  parameter int NUM_MASTERS = 2,
  parameter int AWIDTH      = 8,
  parameter int DWIDTH      = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  evo_csr_arb_if.slave           bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   timeout_o,
  output logic [1:0]             state_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          rr_q, rr_d;
  logic [15:0]            timer_q, timer_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   any_req;
  logic [IW-1:0]          pick;
  logic [IW-1:0]          rr_next;
  logic                   cur_wr, cur_rd, cur_req;
  logic                   expire, accept;

  logic [NUM_MASTERS-1:0] m_waitrequest_c;
  logic [NUM_MASTERS-1:0] m_readdatavalid_c;
  logic [DWIDTH-1:0]      m_readdata_c;
  logic [AWIDTH-1:0]      s_address_c;
  logic [DWIDTH-1:0]      s_writedata_c;
  logic                   s_read_c, s_write_c, timeout_c;

  assign req     = bus.m_read | bus.m_write;
  assign any_req = |req;

  // A write wins over a simultaneous read from the same master.
  assign cur_wr  = bus.m_write[gidx_q];
  assign cur_rd  = bus.m_read[gidx_q] & ~cur_wr;
  assign cur_req = cur_wr | cur_rd;

  // Forced completion lands in the TIMEOUT-th cycle spent in ISSUE or WAIT_RD and
  // takes precedence over a handshake or read response arriving in that same cycle.
  assign expire  = (state_q != ST_IDLE) && (timer_q == 16'(TIMEOUT - 1));
  assign accept  = (state_q == ST_ISSUE) && cur_req && !bus.s_waitrequest && !expire;
  assign rr_next = (gidx_q == IW'(NUM_MASTERS - 1)) ? '0 : gidx_q + 1'b1;

  always_comb begin : p_pick
    int  j;
    logic found;
    j     = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d       = ST_ISSUE;
          gidx_d        = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          timer_d       = '0;
        end
      end
      ST_ISSUE: begin
        if (expire || (accept && cur_wr)) begin
          state_d = ST_IDLE;
          grant_d = '0;
          rr_d    = rr_next;
        end else if (accept) begin
          state_d = ST_WAIT_RD;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_WAIT_RD: begin
        if (expire || bus.s_readdatavalid) begin
          state_d = ST_IDLE;
          grant_d = '0;
          rr_d    = rr_next;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    m_waitrequest_c   = '1;
    m_readdatavalid_c = '0;
    m_readdata_c      = '0;
    s_address_c       = '0;
    s_writedata_c     = '0;
    s_read_c          = 1'b0;
    s_write_c         = 1'b0;
    timeout_c         = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        s_address_c   = bus.m_address[int'(gidx_q)*AWIDTH +: AWIDTH];
        s_writedata_c = bus.m_writedata[int'(gidx_q)*DWIDTH +: DWIDTH];
        if (!expire) begin
          s_read_c  = cur_rd;
          s_write_c = cur_wr;
        end
        if (expire || accept) m_waitrequest_c[gidx_q] = 1'b0;
        if (expire) begin
          timeout_c = 1'b1;
          if (cur_rd) m_readdatavalid_c[gidx_q] = 1'b1;
        end
      end
      ST_WAIT_RD: begin
        if (expire) begin
          timeout_c                  = 1'b1;
          m_readdatavalid_c[gidx_q] = 1'b1;
        end else if (bus.s_readdatavalid) begin
          m_readdatavalid_c[gidx_q] = 1'b1;
          m_readdata_c               = bus.s_readdata;
        end
      end
      default: ;
    endcase
  end

  assign bus.m_waitrequest   = m_waitrequest_c;
  assign bus.m_readdatavalid = m_readdatavalid_c;
  assign bus.m_readdata      = m_readdata_c;
  assign bus.s_address       = s_address_c;
  assign bus.s_writedata     = s_writedata_c;
  assign bus.s_read          = s_read_c;
  assign bus.s_write         = s_write_c;
  assign timeout_o           = timeout_c;
  assign grant_o             = grant_q;
  assign state_o             = state_q;

endmodule

// File: tb/tb_evo_csr_arb.sv
// Directed bench for evo_csr_arb (2 masters, TIMEOUT=16): per-cycle vector table
// followed by hand-written timeout, stuck-waitrequest and mid-read reset sequences.
module tb_evo_csr_arb;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] grant_o;
  logic       timeout_o;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  evo_csr_arb_if #(.NUM_MASTERS(2), .AWIDTH(8), .DWIDTH(32)) bus ();

  evo_csr_arb #(.NUM_MASTERS(2), .AWIDTH(8), .DWIDTH(32), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .grant_o   (grant_o),
    .timeout_o (timeout_o),
    .state_o   (state_o)
  );

  typedef struct {
    logic [1:0]  rd, wr;
    logic [15:0] addr;
    logic [63:0] wd;
    logic        swait, srdv;
    logic [31:0] srdata;
    logic [1:0]  e_grant, e_mwait, e_mrdv;
    logic [31:0] e_mrdata;
    logic        e_srd, e_swr;
    logic [7:0]  e_saddr;
    logic [31:0] e_swdata;
    logic        e_tmo;
  } vec_t;

  localparam int NV = 29;
  vec_t tv[NV];
  int   n_vec = 0;
  int   n_bad = 0;
  int   wacc[2];

  // Inputs for one cycle, with the expected outputs of an idle arbiter.
  function automatic vec_t vin(input logic [1:0] rd, input logic [1:0] wr, input logic [15:0] addr,
                               input logic [63:0] wd, input logic swait, input logic srdv,
                               input logic [31:0] srdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd;
    v.swait = swait; v.srdv = srdv; v.srdata = srdata;
    v.e_grant = 2'b00; v.e_mwait = 2'b11; v.e_mrdv = 2'b00; v.e_mrdata = '0;
    v.e_srd = 1'b0; v.e_swr = 1'b0; v.e_saddr = '0; v.e_swdata = '0; v.e_tmo = 1'b0;
    return v;
  endfunction

  function automatic vec_t vout(input vec_t vi, input logic [1:0] g, input logic [1:0] mw,
                                input logic [1:0] mr, input logic [31:0] md, input logic srd,
                                input logic swr, input logic [7:0] sa, input logic [31:0] sw,
                                input logic tmo);
    vec_t v;
    v = vi;
    v.e_grant = g; v.e_mwait = mw; v.e_mrdv = mr; v.e_mrdata = md;
    v.e_srd = srd; v.e_swr = swr; v.e_saddr = sa; v.e_swdata = sw; v.e_tmo = tmo;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    bus.m_read          = v.rd;
    bus.m_write         = v.wr;
    bus.m_address       = v.addr;
    bus.m_writedata     = v.wd;
    bus.s_waitrequest   = v.swait;
    bus.s_readdatavalid = v.srdv;
    bus.s_readdata      = v.srdata;
  endtask

  task automatic check(input string nm, input vec_t v);
    logic ok;
    ok = (grant_o === v.e_grant) && (bus.m_waitrequest === v.e_mwait) &&
         (bus.m_readdatavalid === v.e_mrdv) && (bus.m_readdata === v.e_mrdata) &&
         (bus.s_read === v.e_srd) && (bus.s_write === v.e_swr) && (timeout_o === v.e_tmo);
    if (v.e_srd || v.e_swr) ok = ok && (bus.s_address === v.e_saddr);
    if (v.e_swr)            ok = ok && (bus.s_writedata === v.e_swdata);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got grant=%b mwait=%b mrdv=%b mrdata=%h srd=%b swr=%b saddr=%h swdata=%h tmo=%b, want grant=%b mwait=%b mrdv=%b mrdata=%h srd=%b swr=%b saddr=%h swdata=%h tmo=%b",
               nm, grant_o, bus.m_waitrequest, bus.m_readdatavalid, bus.m_readdata, bus.s_read,
               bus.s_write, bus.s_address, bus.s_writedata, timeout_o, v.e_grant, v.e_mwait,
               v.e_mrdv, v.e_mrdata, v.e_srd, v.e_swr, v.e_saddr, v.e_swdata, v.e_tmo);
    end
  endtask

  task automatic step(input string nm, input vec_t v);
    @(negedge clk);
    apply(v);
    #1;
    check(nm, v);
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  localparam logic [15:0] ADDR_F = 16'h3020;
  localparam logic [63:0] DATA_F = {32'h22222222, 32'h11111111};
  localparam logic [63:0] DATA_W = {32'hA5A5A5A5, 32'h00000000};
  localparam logic [63:0] DATA_B = {32'h00000000, 32'h33333333};
  localparam logic [63:0] DATA_S = {32'h00000000, 32'h55555555};
  localparam logic [63:0] DATA_6 = {32'h66666666, 32'h00000000};
  localparam logic [63:0] DATA_7 = {32'h00000000, 32'h77777777};
  localparam logic [63:0] DATA_R = {32'h88888888, 32'h99999999};

  initial begin
    vec_t v;
    wacc[0] = 0;
    wacc[1] = 0;

    // Single write by m1, fairness burst, single read by m0, read+write treated as write.
    tv[0] = vin(2'b00, 2'b00, 16'h0000, 64'h0, 1'b0, 1'b0, 32'h0);
    tv[1] = vin(2'b00, 2'b10, 16'h1200, DATA_W, 1'b0, 1'b0, 32'h0);
    tv[2] = vout(vin(2'b00, 2'b10, 16'h1200, DATA_W, 1'b0, 1'b0, 32'h0),
                 2'b10, 2'b01, 2'b00, 32'h0, 1'b0, 1'b1, 8'h12, 32'hA5A5A5A5, 1'b0);
    tv[3] = vin(2'b00, 2'b00, 16'h0000, 64'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tv[4+2*i] = vin(2'b00, 2'b11, ADDR_F, DATA_F, 1'b0, 1'b0, 32'h0);
      if (i % 2 == 0)
        tv[5+2*i] = vout(vin(2'b00, 2'b11, ADDR_F, DATA_F, 1'b0, 1'b0, 32'h0),
                         2'b01, 2'b10, 2'b00, 32'h0, 1'b0, 1'b1, 8'h20, 32'h11111111, 1'b0);
      else
        tv[5+2*i] = vout(vin(2'b00, 2'b11, ADDR_F, DATA_F, 1'b0, 1'b0, 32'h0),
                         2'b10, 2'b01, 2'b00, 32'h0, 1'b0, 1'b1, 8'h30, 32'h22222222, 1'b0);
    end
    tv[20] = vin(2'b01, 2'b00, 16'h0004, 64'h0, 1'b0, 1'b0, 32'h0);
    tv[21] = vout(vin(2'b01, 2'b00, 16'h0004, 64'h0, 1'b0, 1'b0, 32'h0),
                  2'b01, 2'b10, 2'b00, 32'h0, 1'b1, 1'b0, 8'h04, 32'h0, 1'b0);
    tv[22] = vout(vin(2'b00, 2'b00, 16'h0000, 64'h0, 1'b0, 1'b0, 32'h0),
                  2'b01, 2'b11, 2'b00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    tv[23] = vout(vin(2'b00, 2'b00, 16'h0000, 64'h0, 1'b0, 1'b1, 32'h0000C0DE),
                  2'b01, 2'b11, 2'b01, 32'h0000C0DE, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    tv[24] = vin(2'b00, 2'b00, 16'h0000, 64'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    tv[25] = vin(2'b01, 2'b01, 16'h0040, DATA_B, 1'b1, 1'b0, 32'h0);
    tv[26] = vout(vin(2'b01, 2'b01, 16'h0040, DATA_B, 1'b1, 1'b0, 32'h0),
                  2'b01, 2'b11, 2'b00, 32'h0, 1'b0, 1'b1, 8'h40, 32'h33333333, 1'b0);
    tv[27] = vout(vin(2'b01, 2'b01, 16'h0040, DATA_B, 1'b0, 1'b0, 32'h0),
                  2'b01, 2'b10, 2'b00, 32'h0, 1'b0, 1'b1, 8'h40, 32'h33333333, 1'b0);
    tv[28] = vin(2'b00, 2'b00, 16'h0000, 64'h0, 1'b0, 1'b0, 32'h0);

    // Reset state, checked while reset is still asserted.
    reset_n = 1'b0;
    apply(tv[0]);
    #1;
    check("reset_state", tv[0]);
    check_int("reset_fsm_state", int'(state_o), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step($sformatf("vec%0d", i), tv[i]);
      if (i >= 4 && i < 20)
        for (int k = 0; k < 2; k++)
          if (tv[i].wr[k] && bus.m_waitrequest[k] === 1'b0) wacc[k]++;
    end
    check_int("fair_m0_done", wacc[0], 4);
    check_int("fair_m1_done", wacc[1], 4);

    // Read timeout in WAIT_RD, then a late response that must be ignored.
    step("to_rd_idle", vin(2'b01, 2'b00, 16'h0008, 64'h0, 1'b0, 1'b0, 32'h0));
    step("to_rd_accept", vout(vin(2'b01, 2'b00, 16'h0008, 64'h0, 1'b0, 1'b0, 32'h0),
                              2'b01, 2'b10, 2'b00, 32'h0, 1'b1, 1'b0, 8'h08, 32'h0, 1'b0));
    v = vout(vin(2'b00, 2'b00, 16'h0000, 64'h0, 1'b0, 1'b0, 32'h0),
             2'b01, 2'b11, 2'b00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    for (int k = 0; k < 15; k++) step($sformatf("to_rd_wait%0d", k), v);
    step("to_rd_expire", vout(v, 2'b01, 2'b11, 2'b01, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1));
    step("to_rd_after1", vin(2'b00, 2'b00, 16'h0000, 64'h0, 1'b0, 1'b0, 32'h0));
    step("to_rd_after2", vin(2'b00, 2'b00, 16'h0000, 64'h0, 1'b0, 1'b0, 32'h0));
    step("to_rd_late", vin(2'b00, 2'b00, 16'h0000, 64'h0, 1'b0, 1'b1, 32'h0000BEEF));

    // Write against a stuck waitrequest, then the next request is served.
    v = vin(2'b00, 2'b01, 16'h0050, DATA_S, 1'b1, 1'b0, 32'h0);
    step("stuck_idle", v);
    for (int k = 0; k < 15; k++)
      step($sformatf("stuck_wait%0d", k),
           vout(v, 2'b01, 2'b11, 2'b00, 32'h0, 1'b0, 1'b1, 8'h50, 32'h55555555, 1'b0));
    step("stuck_expire", vout(v, 2'b01, 2'b10, 2'b00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1));
    v = vin(2'b00, 2'b10, 16'h6000, DATA_6, 1'b0, 1'b0, 32'h0);
    step("next_idle", v);
    step("next_accept", vout(v, 2'b10, 2'b01, 2'b00, 32'h0, 1'b0, 1'b1, 8'h60, 32'h66666666, 1'b0));

    // m0 write moves the pointer to m1, then m0 read is cut by reset in WAIT_RD.
    v = vin(2'b00, 2'b01, 16'h0070, DATA_7, 1'b0, 1'b0, 32'h0);
    step("pre_wr_idle", v);
    step("pre_wr_accept", vout(v, 2'b01, 2'b10, 2'b00, 32'h0, 1'b0, 1'b1, 8'h70, 32'h77777777, 1'b0));
    v = vin(2'b01, 2'b00, 16'h000C, 64'h0, 1'b0, 1'b0, 32'h0);
    step("rst_rd_idle", v);
    step("rst_rd_accept", vout(v, 2'b01, 2'b10, 2'b00, 32'h0, 1'b1, 1'b0, 8'h0C, 32'h0, 1'b0));
    step("rst_rd_wait", vout(vin(2'b00, 2'b00, 16'h0000, 64'h0, 1'b0, 1'b0, 32'h0),
                             2'b01, 2'b11, 2'b00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0));
    @(negedge clk);
    reset_n = 1'b0;
    v = vin(2'b00, 2'b00, 16'h0000, 64'h0, 1'b0, 1'b1, 32'h12345678);
    apply(v);
    #1;
    check("rst_mid_read", v);
    check_int("rst_mid_fsm_state", int'(state_o), 0);
    v = vin(2'b00, 2'b11, 16'h8180, DATA_R, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    apply(v);
    #1;
    check("rst_release_idle", v);
    step("rst_prio_m0", vout(v, 2'b01, 2'b10, 2'b00, 32'h0, 1'b0, 1'b1, 8'h80, 32'h99999999, 1'b0));
    step("final_idle", vin(2'b00, 2'b00, 16'h0000, 64'h0, 1'b0, 1'b0, 32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
